// File: rtl/pipeline_sequencer.sv
// Pipeline bubble, halt-drain and bus wait-state controller for the two-stage core.
// Optional PIPE_STATS_EN adds saturating NOP / stall cycle counters as extra outputs.
module pipeline_sequencer #(
    parameter int CF_BUBBLES   = 1,
    parameter int HALT_DRAIN   = 4,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_access_cycle,
    input  logic        control_flow_start_cycle,
    input  logic        halting,
    input  logic        bus_cycle_active,
    input  logic        bus_ready,
    output logic        insert_nop,
    output logic        pc_inc,
    output logic        stall,
    output logic        halted,
    output logic        timeout_error,
    output logic [1:0]  fsm_state
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0] stat_nop_cycles,
    output logic [31:0] stat_stall_cycles
`endif
);

    localparam int BW = $clog2(CF_BUBBLES + 1);
    localparam int HW = $clog2(HALT_DRAIN + 1);
    localparam int WW = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [BW-1:0] BUB_LOAD  = BW'(CF_BUBBLES);
    localparam logic [BW-1:0] BUB_ONE   = BW'(1);
    localparam logic [HW-1:0] HALT_LAST = HW'(HALT_DRAIN - 1);
    localparam logic [HW-1:0] HALT_MAX  = HW'(HALT_DRAIN);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BUBBLE  = 2'd1,
        ST_HALTED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t          state;
    logic [BW-1:0]   bubble_cnt;
    logic [HW-1:0]   halt_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            wait_now;
    logic            run_nop;

    assign wait_now  = bus_cycle_active & ~bus_ready;
    assign run_nop   = memory_access_cycle | control_flow_start_cycle | halting;
    assign fsm_state = state;

    // Outputs follow the registered state; reset forces a NOP with the PC held still.
    always_comb begin
        insert_nop = 1'b1;
        pc_inc     = 1'b0;
        stall      = 1'b0;
        if (reset) begin
            unique case (state)
                ST_RUN: begin
                    stall      = wait_now;
                    insert_nop = run_nop;
                    pc_inc     = ~run_nop & ~wait_now;
                end
                ST_BUBBLE: stall = wait_now;
                ST_HALTED: stall = 1'b0;
                ST_FAULT:  stall = 1'b1;
                default:   stall = 1'b0;
            endcase
        end
    end

    // A stalled cycle only advances the wait counter; everything else is frozen.
    // Later assignments to state win, so HALTED overrides a same-edge BUBBLE entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_RUN;
            bubble_cnt    <= '0;
            halt_cnt      <= '0;
            wait_cnt      <= '0;
            halted        <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN, ST_BUBBLE: begin
                    if (wait_now) begin
                        if (wait_cnt == WAIT_LAST) begin
                            state         <= ST_FAULT;
                            timeout_error <= 1'b1;
                        end
                        if (wait_cnt != WAIT_MAX)
                            wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= '0;
                        if (state == ST_BUBBLE) begin
                            if (bubble_cnt <= BUB_ONE) begin
                                state      <= ST_RUN;
                                bubble_cnt <= '0;
                            end else begin
                                bubble_cnt <= bubble_cnt - 1'b1;
                            end
                        end else if (control_flow_start_cycle) begin
                            state      <= ST_BUBBLE;
                            bubble_cnt <= BUB_LOAD;
                        end
                        if (halting) begin
                            if (halt_cnt == HALT_LAST) begin
                                state  <= ST_HALTED;
                                halted <= 1'b1;
                            end
                            if (halt_cnt != HALT_MAX)
                                halt_cnt <= halt_cnt + 1'b1;
                        end
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                ST_FAULT:  state <= ST_FAULT;
                default:   state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_nop_cycles   <= '0;
            stat_stall_cycles <= '0;
        end else if (!halted && !timeout_error) begin
            if (insert_nop && stat_nop_cycles != 32'hFFFF_FFFF)
                stat_nop_cycles <= stat_nop_cycles + 32'd1;
            if (stall && stat_stall_cycles != 32'hFFFF_FFFF)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized bench for pipeline_sequencer: two parameterisations share stimulus and are
// each checked every cycle against a behavioural model of the bubble/halt/wait rules.
module tb_pipeline_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, mac, cfs, hlt, bca, brdy;
    logic nop0, pc0, st0, hd0, te0;
    logic nop1, pc1, st1, hd1, te1;
    logic [1:0] fs0, fs1;
`ifdef PIPE_STATS_EN
    logic [31:0] sn0, ss0, sn1, ss1;
`endif

    pipeline_sequencer dut0 (
        .clock(clock), .reset(reset),
        .memory_access_cycle(mac), .control_flow_start_cycle(cfs), .halting(hlt),
        .bus_cycle_active(bca), .bus_ready(brdy),
        .insert_nop(nop0), .pc_inc(pc0), .stall(st0), .halted(hd0),
        .timeout_error(te0), .fsm_state(fs0)
`ifdef PIPE_STATS_EN
        , .stat_nop_cycles(sn0), .stat_stall_cycles(ss0)
`endif
    );

    pipeline_sequencer #(.CF_BUBBLES(3), .HALT_DRAIN(2), .WAIT_TIMEOUT(5)) dut1 (
        .clock(clock), .reset(reset),
        .memory_access_cycle(mac), .control_flow_start_cycle(cfs), .halting(hlt),
        .bus_cycle_active(bca), .bus_ready(brdy),
        .insert_nop(nop1), .pc_inc(pc1), .stall(st1), .halted(hd1),
        .timeout_error(te1), .fsm_state(fs1)
`ifdef PIPE_STATS_EN
        , .stat_nop_cycles(sn1), .stat_stall_cycles(ss1)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: NOPs still owed after the control-flow cycle, halting cycles seen,
    // current run of wait cycles, plus the two sticky outcomes.
    int     p_cf [2] = '{1, 3};
    int     p_hd [2] = '{4, 2};
    int     p_wt [2] = '{16, 5};
    int     m_bub [2];
    int     m_halt [2];
    int     m_wait [2];
    bit     m_hd [2];
    bit     m_flt [2];
    longint m_snop [2];
    longint m_sst [2];

    function automatic void model_out(input int k, output bit e_nop, output bit e_pc, output bit e_st);
        if (!reset) begin
            e_nop = 1; e_pc = 0; e_st = 0;
        end else if (m_flt[k]) begin
            e_nop = 1; e_pc = 0; e_st = 1;
        end else if (m_hd[k]) begin
            e_nop = 1; e_pc = 0; e_st = 0;
        end else begin
            e_st  = bca && !brdy;
            e_nop = (m_bub[k] > 0) || mac || cfs || hlt;
            e_pc  = !e_nop && !e_st;
        end
    endfunction

    task automatic model_step(input int k);
        bit e_nop, e_pc, e_st;
        model_out(k, e_nop, e_pc, e_st);
        if (!reset) begin
            m_bub[k] = 0; m_halt[k] = 0; m_wait[k] = 0;
            m_hd[k] = 0; m_flt[k] = 0; m_snop[k] = 0; m_sst[k] = 0;
        end else if (!m_hd[k] && !m_flt[k]) begin
            if (e_nop) m_snop[k]++;
            if (e_st)  m_sst[k]++;
            if (bca && !brdy) begin
                m_wait[k]++;
                if (m_wait[k] == p_wt[k]) m_flt[k] = 1;
            end else begin
                m_wait[k] = 0;
                if (m_bub[k] > 0) m_bub[k]--;
                else if (cfs) m_bub[k] = p_cf[k];
                if (hlt) begin
                    m_halt[k]++;
                    if (m_halt[k] == p_hd[k]) m_hd[k] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        bit e_nop, e_pc, e_st;
        for (int k = 0; k < 2; k++) begin
            model_out(k, e_nop, e_pc, e_st);
            check($sformatf("insert_nop%0d", k), k == 0 ? nop0 : nop1, e_nop);
            check($sformatf("pc_inc%0d", k),     k == 0 ? pc0  : pc1,  e_pc);
            check($sformatf("stall%0d", k),      k == 0 ? st0  : st1,  e_st);
            check($sformatf("halted%0d", k),     k == 0 ? hd0  : hd1,  m_hd[k]);
            check($sformatf("timeout%0d", k),    k == 0 ? te0  : te1,  m_flt[k]);
`ifdef PIPE_STATS_EN
            check($sformatf("stat_nop%0d", k),   k == 0 ? sn0 : sn1, 32'(m_snop[k]));
            check($sformatf("stat_stall%0d", k), k == 0 ? ss0 : ss1, 32'(m_sst[k]));
`endif
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic run_cycle();
        @(negedge clock);
        check_all();
        model_step(0);
        model_step(1);
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit r, input bit m, input bit c, input bit h, input bit a, input bit y);
        reset = r; mac = m; cfs = c; hlt = h; bca = a; brdy = y;
    endtask

    task automatic drive_n(input int n, input bit r, input bit m, input bit c, input bit h,
                           input bit a, input bit y);
        for (int i = 0; i < n; i++) begin
            drive(r, m, c, h, a, y);
            run_cycle();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_bub[k] = 0; m_halt[k] = 0; m_wait[k] = 0;
            m_hd[k] = 0; m_flt[k] = 0; m_snop[k] = 0; m_sst[k] = 0;
        end
        // Reset held with every input high, then idle.
        drive_n(3, 0, 1, 1, 1, 1, 1);
        drive_n(3, 1, 0, 0, 0, 0, 1);
        // Branch pulse, then five wait cycles inside the bubble.
        drive_n(1, 1, 0, 1, 0, 0, 1);
        drive_n(5, 1, 0, 0, 0, 1, 0);
        drive_n(6, 1, 0, 0, 0, 0, 1);
        // Branch plus a five-cycle wait outside the bubble.
        drive_n(1, 0, 0, 0, 0, 0, 1);
        drive_n(1, 1, 0, 1, 0, 0, 1);
        drive_n(4, 1, 0, 0, 0, 0, 1);
        drive_n(5, 1, 0, 0, 0, 1, 0);
        drive_n(2, 1, 0, 0, 0, 0, 1);
        // Continuous halting.
        drive_n(7, 1, 0, 0, 1, 0, 1);
        // Halting 2, drop 3, reassert.
        drive_n(1, 0, 0, 0, 0, 0, 1);
        drive_n(2, 1, 0, 0, 1, 0, 1);
        drive_n(3, 1, 0, 0, 0, 0, 1);
        drive_n(4, 1, 0, 0, 1, 0, 1);
        // Branch together with halting.
        drive_n(1, 0, 0, 0, 0, 0, 1);
        drive_n(1, 1, 0, 1, 1, 0, 1);
        drive_n(5, 1, 0, 0, 1, 0, 1);
        // Bus never ready: timeout on both instances.
        drive_n(1, 0, 0, 0, 0, 0, 1);
        drive_n(20, 1, 0, 0, 0, 1, 0);
        drive_n(3, 1, 1, 1, 1, 0, 1);
        drive_n(1, 0, 0, 0, 0, 0, 1);

        for (int ep = 0; ep < 60; ep++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(20, 50);
            if ($urandom_range(0, 2) == 0)
                drive_n($urandom_range(1, 3), 0, $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                bit r, m, c, h, a, y;
                r = ($urandom_range(0, 59) != 0);
                m = ($urandom_range(0, 3) == 0);
                c = ($urandom_range(0, 7) == 0);
                h = ($urandom_range(0, 15) == 0);
                a = ($urandom_range(0, 2) == 0);
                y = ($urandom_range(0, 3) != 0);
                case (mode)
                    1: begin a = 1; y = ($urandom_range(0, 9) == 0); end
                    2: begin a = 1; y = 0; end
                    3: h = ($urandom_range(0, 3) != 0);
                    default: ;
                endcase
                drive(r, m, c, h, a, y);
                run_cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Parametrised pipeline-bubble, halt and bus-wait controller for the two-stage core (memorystage1 / registersstage2).
- Replaces the fixed NOP-insertion, PC-increment and two-bit halt-counter logic in the core top with one sequential block.
- Bubble length and halt drain are configurable.
- Adds bus wait-state stalling with a timeout fault, which the current core lacks.

Parameters:
CF_BUBBLES, 1, extra NOP cycles after the control-flow start cycle (>=1); the default reproduces the current 2-NOP branch/jump shadow
HALT_DRAIN, 4, halting cycles counted before halted asserts (>=1)
WAIT_TIMEOUT, 16, consecutive wait-state cycles tolerated before fault (>=1)

Ports:
clock  input  1  core clock
reset  input  1  synchronous reset, active-low
memory_access_cycle  input  1  memorystage1 is issuing a load/store this cycle
control_flow_start_cycle  input  1  memorystage1 decoded a branch/jump/call
halting  input  1  memorystage1 holds HALT
bus_cycle_active  input  1  a bus read or write is driven this cycle
bus_ready  input  1  slave completes the current bus cycle this clock
insert_nop  output  1  replace the fetched word with OPCODE_NOP
pc_inc  output  1  increment the program counter
stall  output  1  hold the program counter, both pipeline stages and the status register
halted  output  1  halt drain complete (registered, sticky)
timeout_error  output  1  bus wait timeout occurred (registered, sticky)

Behaviour:
- Reset:
  - Applies on a clock edge when reset==0; takes effect whatever the current state, including mid-bubble, mid-wait or halted.
  - Clears state to RUN and zeroes the bubble, halt and wait counters; halted=0, timeout_error=0.
  - While reset==0: insert_nop=1, pc_inc=0, stall=0.
- States: RUN, BUBBLE, HALTED, FAULT (registered). FAULT has priority over HALTED, HALTED over BUBBLE.
- stall (combinational) = bus_cycle_active & ~bus_ready in RUN/BUBBLE; 1 in FAULT; 0 in HALTED.
- While stall=1, every counter except the wait counter and all state transitions are frozen; pc_inc=0.
- RUN:
  - insert_nop = memory_access_cycle | control_flow_start_cycle | halting.
  - pc_inc = ~insert_nop & ~stall.
  - control_flow_start_cycle & ~stall -> BUBBLE; bubble counter loaded with CF_BUBBLES.
- BUBBLE:
  - insert_nop=1, pc_inc=0; counter decrements each unstalled cycle; at 1 -> RUN on that edge.
  - Total NOP cycles per control flow = 1 + CF_BUBBLES.
  - control_flow_start_cycle in BUBBLE is ignored (it cannot legally occur, because NOPs are being issued).
- Halt:
  - Each unstalled cycle with halting=1 increments the halt counter in RUN or BUBBLE.
  - The counter is not cleared if halting drops.
  - On the edge where the counter already equals HALT_DRAIN-1 and halting=1: state -> HALTED, halted<=1.
  - halted therefore rises after exactly HALT_DRAIN halting cycles.
- HALTED: insert_nop=1, pc_inc=0, stall=0; the only exit is reset.
- Wait:
  - Wait counter increments each cycle with bus_cycle_active & ~bus_ready, and clears on any cycle with bus_ready=1 or bus_cycle_active=0.
  - If the counter equals WAIT_TIMEOUT-1 and the cycle is still not ready: state -> FAULT, timeout_error<=1.
  - The fault triggers on the WAIT_TIMEOUT-th consecutive wait cycle.
- FAULT: insert_nop=1, pc_inc=0, stall=1 until reset; halted is unchanged.
- Simultaneous control_flow_start_cycle and halting in RUN: both take effect; HALTED overrides BUBBLE when the drain completes.
- Counter widths: $clog2(param+1) bits each. Counters saturate and never wrap.

Optional Feature:
- Macro: PIPE_STATS_EN.
- When defined, two output ports are added:
  - stat_nop_cycles [31:0]: counts cycles with insert_nop=1 outside reset.
  - stat_stall_cycles [31:0]: counts cycles with stall=1.
- Both counters are zeroed by reset, saturate at 32'hFFFFFFFF, and are frozen once halted=1 or timeout_error=1.
- When undefined, the ports and counters do not exist and core behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all inputs=1 -> insert_nop=1, pc_inc=0, stall=0, halted=0, timeout_error=0. Release -> with idle inputs, pc_inc=1 on the next cycle.
- Branch: defaults, one-cycle control_flow_start_cycle pulse -> insert_nop=1 for exactly 2 cycles, pc_inc=0 for both, then pc_inc=1. Repeat with CF_BUBBLES=3 -> 4 NOP cycles.
- Wait stall: bus_cycle_active=1 with bus_ready=0 for 5 cycles mid-BUBBLE -> stall=1 for those 5 cycles. Bubble completes after its remaining unstalled cycles; timeout_error stays 0.
- Timeout: WAIT_TIMEOUT=16, bus_ready held 0 -> timeout_error rises after the 16th wait cycle; stall=1 and insert_nop=1 persist until reset=0.
- Halt: halting=1 continuously -> halted=1 after exactly 4 cycles (HALT_DRAIN=4). Also halting 2 cycles, drop 3 cycles, reassert -> halted after 2 more cycles.
- Stats (PIPE_STATS_EN): branch plus a 5-cycle wait -> stat_nop_cycles=2, stat_stall_cycles=5. Both counters freeze once halted=1.
